freq_band_ctrl: RTL

Parametrised successor to the single-shot frequency-to-divider mapper. It takes period measurements from the frequency detector and classifies each into one of NUM_BANDS octave bands. A band switch needs CONFIRM_CNT consecutive agreeing measurements, and the block then holds a programmable settle window before reporting `stable`. It drives the ADC sample-clock divider and adds out-of-range reporting and a manual band override.

---
 rtl/freq_band_ctrl_if.sv | 25 ++
 rtl/freq_band_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/freq_band_ctrl_if.sv
// Measurement, manual-override and divider-control signals of freq_band_ctrl.
interface freq_band_ctrl_if #(
  parameter int COUNTER_WIDTH = 18,
  parameter int DIV_WIDTH     = 12,
  parameter int BAND_W        = 3
);
  logic                     period_valid;
  logic [COUNTER_WIDTH-1:0] period;
  logic                     manual_en;
  logic [BAND_W-1:0]        manual_band;
  logic [DIV_WIDTH-1:0]     div;
  logic [BAND_W-1:0]        band;
  logic                     div_update;
  logic                     stable;
  logic                     out_of_range;

  modport master (
    output period_valid, period, manual_en, manual_band,
    input  div, band, div_update, stable, out_of_range
  );
  modport slave (
    input  period_valid, period, manual_en, manual_band,
    output div, band, div_update, stable, out_of_range
  );
endinterface

// File: rtl/freq_band_ctrl.sv
// Classifies period measurements into octave bands, confirms band switches over
// consecutive samples, drives the ADC clock divider and reports settling.
module freq_band_ctrl #(
  parameter int                               COUNTER_WIDTH = 18,
  parameter int                               DIV_WIDTH     = 12,
  parameter int                               NUM_BANDS     = 7,
  parameter int                               LO_PERIOD     = 1562,
  parameter logic [NUM_BANDS*DIV_WIDTH-1:0]   DIV_TABLE     = {12'd999, 12'd499, 12'd249, 12'd124,
                                                               12'd59, 12'd29, 12'd14},
  parameter int                               CONFIRM_CNT   = 2,
  parameter int                               SETTLE_CYCLES = 16,
  parameter int                               RESET_BAND    = 0,
  parameter int                               BAND_W        = $clog2(NUM_BANDS)
) (
  input logic             clk,
  input logic             rst,
  freq_band_ctrl_if.slave bus
);
  localparam int                CONF_W   = $clog2(CONFIRM_CNT + 1);
  localparam int                SET_W    = $clog2(SETTLE_CYCLES + 1);
  localparam int                EXT_W    = COUNTER_WIDTH + 1;
  localparam logic [EXT_W-1:0]  LO_EXT   = EXT_W'(LO_PERIOD);
  localparam logic [BAND_W-1:0] RST_BAND = BAND_W'(RESET_BAND);
  localparam logic [BAND_W-1:0] TOP_BAND = BAND_W'(NUM_BANDS - 1);

  function automatic logic [DIV_WIDTH-1:0] div_of(input logic [BAND_W-1:0] b);
    return DIV_TABLE[int'(b)*DIV_WIDTH +: DIV_WIDTH];
  endfunction

  logic                 s1_valid_r, s1_oor_r, man_en_r;
  logic [BAND_W-1:0]    s1_band_r, man_band_r;
  logic [BAND_W-1:0]    band_r, pend_r;
  logic [DIV_WIDTH-1:0] div_r;
  logic                 upd_r, stable_r, oor_r;
  logic [CONF_W-1:0]    conf_r;
  logic [SET_W-1:0]     settle_r;

  logic [EXT_W-1:0]     period_ext_s;
  logic [BAND_W-1:0]    cand_s, man_band_s, sw_band_s, pend_n, band_n;
  logic                 oor_s, sw_s, oor_n, upd_n, stable_n;
  logic [CONF_W-1:0]    conf_n;
  logic [SET_W-1:0]     settle_n;
  logic [DIV_WIDTH-1:0] div_n;

  // Thresholds are widened by one bit so the top band edge never wraps.
  always_comb begin
    period_ext_s = {1'b0, bus.period};
    cand_s       = '0;
    for (int k = 1; k < NUM_BANDS; k++) begin
      if (period_ext_s > (LO_EXT << k)) begin
        cand_s = BAND_W'(k);
      end else begin
        cand_s = cand_s;
      end
    end
    oor_s = (period_ext_s <= LO_EXT) || (period_ext_s > (LO_EXT << NUM_BANDS));
  end

  always_comb begin
    if (int'(man_band_r) >= NUM_BANDS) begin
      man_band_s = TOP_BAND;
    end else begin
      man_band_s = man_band_r;
    end
  end

  // Stage 1 capture and manual-input registration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_band_r  <= '0;
      s1_oor_r   <= 1'b0;
      man_en_r   <= 1'b0;
      man_band_r <= '0;
    end else begin
      s1_valid_r <= bus.period_valid & ~bus.manual_en;
      s1_band_r  <= cand_s;
      s1_oor_r   <= oor_s;
      man_en_r   <= bus.manual_en;
      man_band_r <= bus.manual_band;
    end
  end

  // Priority: manual override, then a confirmed switch, then stage-2 sample rules.
  always_comb begin
    pend_n    = pend_r;
    conf_n    = conf_r;
    oor_n     = oor_r;
    sw_s      = 1'b0;
    sw_band_s = band_r;
    if (man_en_r) begin
      pend_n = '0;
      conf_n = '0;
      if (man_band_s != band_r) begin
        sw_s      = 1'b1;
        sw_band_s = man_band_s;
      end else begin
        sw_s = 1'b0;
      end
    end else if (conf_r == CONF_W'(CONFIRM_CNT)) begin
      sw_s      = 1'b1;
      sw_band_s = pend_r;
      pend_n    = '0;
      conf_n    = '0;
    end else if (s1_valid_r) begin
      if (!stable_r) begin
        pend_n = '0;
        conf_n = '0;
      end else if (s1_oor_r) begin
        oor_n  = 1'b1;
        pend_n = '0;
        conf_n = '0;
      end else if (s1_band_r == band_r) begin
        oor_n  = 1'b0;
        conf_n = '0;
      end else if (s1_band_r == pend_r) begin
        oor_n  = 1'b0;
        conf_n = (conf_r >= CONF_W'(CONFIRM_CNT)) ? conf_r : conf_r + CONF_W'(1);
      end else begin
        oor_n  = 1'b0;
        pend_n = s1_band_r;
        conf_n = CONF_W'(1);
      end
    end else begin
      oor_n = oor_r;
    end
  end

  always_comb begin
    if (sw_s) begin
      band_n   = sw_band_s;
      div_n    = div_of(sw_band_s);
      upd_n    = 1'b1;
      stable_n = 1'b0;
      settle_n = SET_W'(SETTLE_CYCLES);
    end else begin
      band_n = band_r;
      div_n  = div_r;
      upd_n  = 1'b0;
      if (settle_r != '0) begin
        settle_n = settle_r - SET_W'(1);
        stable_n = (settle_r == SET_W'(1));
      end else begin
        settle_n = settle_r;
        stable_n = stable_r;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      band_r   <= RST_BAND;
      div_r    <= div_of(RST_BAND);
      upd_r    <= 1'b0;
      stable_r <= 1'b1;
      oor_r    <= 1'b0;
      pend_r   <= '0;
      conf_r   <= '0;
      settle_r <= '0;
    end else begin
      band_r   <= band_n;
      div_r    <= div_n;
      upd_r    <= upd_n;
      stable_r <= stable_n;
      oor_r    <= oor_n;
      pend_r   <= pend_n;
      conf_r   <= conf_n;
      settle_r <= settle_n;
    end
  end

  assign bus.band         = band_r;
  assign bus.div          = div_r;
  assign bus.div_update   = upd_r;
  assign bus.stable       = stable_r;
  assign bus.out_of_range = oor_r;
endmodule
